pmem_gpio_bank: RTL and testbench

Memory-mapped multi-port GPIO peripheral on the pmem byte bus. It is the parametrised successor of the single 8-bit PIN/DDR/PORT block. It provides NUM_PORTS 8-bit ports, each with a two-flop input synchroniser, and a per-pin pin-change interrupt with a masked, write-1-to-clear flag register. It drives a single irq line to the core.

---
 rtl/pmem_gpio_pkg.sv | 23 ++
 rtl/pmem_gpio_port.sv | 94 +++++++++
 rtl/pmem_gpio_bank.sv | 135 +++++++++++++
 tb/tb_pmem_gpio_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_gpio_pkg.sv
// Shared constants and types for the pmem GPIO bank: register offsets, stride, data width.
package pmem_gpio_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned PORT_STRIDE = 4;

  localparam logic [1:0] OFF_PIN   = 2'd0;
  localparam logic [1:0] OFF_DDR   = 2'd1;
  localparam logic [1:0] OFF_PORT  = 2'd2;
  localparam logic [1:0] OFF_PCMSK = 2'd3;

  // Offsets of the global registers, relative to the end of the per-port window.
  localparam logic [7:0] OFF_PCIFR = 8'd0;
  localparam logic [7:0] OFF_PCICR = 8'd1;

  typedef enum logic [1:0] {
    RegPin   = OFF_PIN,
    RegDdr   = OFF_DDR,
    RegPort  = OFF_PORT,
    RegPcmsk = OFF_PCMSK
  } port_reg_e;

endpackage

// File: rtl/pmem_gpio_port.sv
// One 8-bit GPIO port: DDR/PORT/PCMSK registers, input synchroniser, pin-change detect.
// PCMSK, the third synchroniser stage and chg_o exist only with PMEM_GPIO_IRQ_EN.
module pmem_gpio_port
  import pmem_gpio_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic              past_write_i,
  input  port_reg_e         reg_sel_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] io_in_i,
  output logic [DATA_W-1:0] io_out_o,
  output logic [DATA_W-1:0] io_oeb_o,
`ifdef PMEM_GPIO_IRQ_EN
  output logic              chg_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] s1_q, s2_q;
  logic [DATA_W-1:0] port_q, port_d;
  logic [DATA_W-1:0] oeb_q, oeb_d;
`ifdef PMEM_GPIO_IRQ_EN
  logic [DATA_W-1:0] s3_q;
  logic [DATA_W-1:0] pcmsk_q, pcmsk_d;
`endif

  always_comb begin
    port_d = port_q;
    oeb_d  = oeb_q;
`ifdef PMEM_GPIO_IRQ_EN
    pcmsk_d = pcmsk_q;
`endif
    if (wr_en_i) begin
      case (reg_sel_i)
        // Toggle only on the first cycle of a held write so a burst flips once.
        RegPin:  if (!past_write_i) port_d = port_q ^ wdata_i;
        RegDdr:  oeb_d = ~wdata_i;
        RegPort: port_d = wdata_i;
        RegPcmsk: begin
`ifdef PMEM_GPIO_IRQ_EN
          pcmsk_d = wdata_i;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      port_q <= '0;
      oeb_q  <= '1;
`ifdef PMEM_GPIO_IRQ_EN
      s3_q    <= '0;
      pcmsk_q <= '0;
`endif
    end else begin
      s1_q   <= io_in_i;
      s2_q   <= s1_q;
      port_q <= port_d;
      oeb_q  <= oeb_d;
`ifdef PMEM_GPIO_IRQ_EN
      s3_q    <= s2_q;
      pcmsk_q <= pcmsk_d;
`endif
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_sel_i)
      RegPin:  rdata_o = s2_q;
      RegDdr:  rdata_o = ~oeb_q;
      RegPort: rdata_o = port_q;
      RegPcmsk: begin
`ifdef PMEM_GPIO_IRQ_EN
        rdata_o = pcmsk_q;
`endif
      end
      default: ;
    endcase
  end

  assign io_out_o = port_q;
  assign io_oeb_o = oeb_q;
`ifdef PMEM_GPIO_IRQ_EN
  assign chg_o = |((s2_q ^ s3_q) & pcmsk_q);
`endif

endmodule

// File: rtl/pmem_gpio_bank.sv
// Multi-port GPIO on the pmem byte bus: address decode, read mux, handshake, PCIFR/PCICR and irq.
// Pin-change interrupts are built only when PMEM_GPIO_IRQ_EN is defined.
module pmem_gpio_bank
  import pmem_gpio_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter logic [7:0]  BASE_ADDR = 8'h36
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        select,
  input  logic [7:0]                  addr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        write,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_ready,
  input  logic [DATA_W*NUM_PORTS-1:0] io_in,
  output logic [DATA_W*NUM_PORTS-1:0] io_out,
  output logic [DATA_W*NUM_PORTS-1:0] io_oeb,
  output logic                        irq
);

  localparam logic [7:0] PortSpan = 8'(PORT_STRIDE * NUM_PORTS);

  // Addresses below BASE_ADDR wrap to large offsets and fall outside every window.
  logic [7:0] offset;
  logic       port_hit;
  logic [2:0] port_idx;
  port_reg_e  reg_sel;
  logic       bus_wr;

  assign offset   = addr - BASE_ADDR;
  assign port_hit = offset < PortSpan;
  assign port_idx = offset[4:2];
  assign reg_sel  = port_reg_e'(offset[1:0]);
  assign bus_wr   = select & write;

  logic [DATA_W-1:0] rdata [NUM_PORTS];
  logic              past_write_q, past_write_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_ready_q, data_ready_d;
  logic [DATA_W-1:0] rd_val;

`ifdef PMEM_GPIO_IRQ_EN
  localparam logic [7:0] PcifrOff = PortSpan + OFF_PCIFR;
  localparam logic [7:0] PcicrOff = PortSpan + OFF_PCICR;

  logic [NUM_PORTS-1:0] chg;
  logic [NUM_PORTS-1:0] pcifr_q, pcifr_d;
  logic [NUM_PORTS-1:0] pcicr_q, pcicr_d;
  logic                 irq_q, irq_d;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic wr_en;
    assign wr_en = bus_wr & port_hit & (port_idx == 3'(p));

    pmem_gpio_port u_port (
      .clock        (clock),
      .reset        (reset),
      .wr_en_i      (wr_en),
      .past_write_i (past_write_q),
      .reg_sel_i    (reg_sel),
      .wdata_i      (data_in),
      .io_in_i      (io_in[DATA_W*p +: DATA_W]),
      .io_out_o     (io_out[DATA_W*p +: DATA_W]),
      .io_oeb_o     (io_oeb[DATA_W*p +: DATA_W]),
`ifdef PMEM_GPIO_IRQ_EN
      .chg_o        (chg[p]),
`endif
      .rdata_o      (rdata[p])
    );
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (port_hit && port_idx == 3'(p)) rd_val = rdata[p];
    end
`ifdef PMEM_GPIO_IRQ_EN
    if (offset == PcifrOff) rd_val[NUM_PORTS-1:0] = pcifr_q;
    if (offset == PcicrOff) rd_val[NUM_PORTS-1:0] = pcicr_q;
`endif
  end

  always_comb begin
    past_write_d = bus_wr;
    data_ready_d = select;
    data_out_d   = data_out_q;
    if (select) data_out_d = write ? '0 : rd_val;
  end

`ifdef PMEM_GPIO_IRQ_EN
  always_comb begin
    pcifr_d = pcifr_q;
    pcicr_d = pcicr_q;
    if (bus_wr && offset == PcifrOff) pcifr_d = pcifr_q & ~data_in[NUM_PORTS-1:0];
    if (bus_wr && offset == PcicrOff) pcicr_d = data_in[NUM_PORTS-1:0];
    // A new change on the clearing edge must not be lost, so set is applied last.
    pcifr_d = pcifr_d | chg;
    irq_d   = |(pcifr_d & pcicr_q);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      past_write_q <= 1'b0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
`ifdef PMEM_GPIO_IRQ_EN
      pcifr_q <= '0;
      pcicr_q <= '0;
      irq_q   <= 1'b0;
`endif
    end else begin
      past_write_q <= past_write_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
`ifdef PMEM_GPIO_IRQ_EN
      pcifr_q <= pcifr_d;
      pcicr_q <= pcicr_d;
      irq_q   <= irq_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
`ifdef PMEM_GPIO_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_gpio_bank.sv
// Bench for pmem_gpio_bank: a register-map model checked every cycle plus directed literals.
module tb_pmem_gpio_bank;

  localparam int unsigned N    = 2;
  localparam int unsigned W    = 8 * N;
  localparam logic [7:0]  BASE = 8'h36;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         select = 1'b0;
  logic [7:0]   addr = 8'h00;
  logic [7:0]   data_in = 8'h00;
  logic         write = 1'b0;
  logic [7:0]   data_out;
  logic         data_ready;
  logic [W-1:0] io_in = '0;
  logic [W-1:0] io_out;
  logic [W-1:0] io_oeb;
  logic         irq;

  int errors = 0;
  int checks = 0;

  pmem_gpio_bank #(
    .NUM_PORTS (N),
    .BASE_ADDR (BASE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .select     (select),
    .addr       (addr),
    .data_in    (data_in),
    .write      (write),
    .data_out   (data_out),
    .data_ready (data_ready),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: plain per-port arrays plus a history of the last three io_in samples.
  logic [7:0]   m_port [N];
  logic [7:0]   m_ddr  [N];
`ifdef PMEM_GPIO_IRQ_EN
  logic [7:0]   m_msk  [N];
`endif
  logic [N-1:0] m_flag, m_cr;
  logic         m_irq, m_rdy, m_past;
  logic [7:0]   m_dout;
  logic [W-1:0] h0, h1, h2;
  bit           model_on = 1'b0;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] rv;
    rv = 8'h00;
    for (int p = 0; p < N; p++) begin
      if (a == 8'(BASE + 4 * p))     rv = h1[8*p +: 8];
      if (a == 8'(BASE + 4 * p + 1)) rv = m_ddr[p];
      if (a == 8'(BASE + 4 * p + 2)) rv = m_port[p];
`ifdef PMEM_GPIO_IRQ_EN
      if (a == 8'(BASE + 4 * p + 3)) rv = m_msk[p];
`endif
    end
`ifdef PMEM_GPIO_IRQ_EN
    if (a == 8'(BASE + 4 * N))     rv = 8'(m_flag);
    if (a == 8'(BASE + 4 * N + 1)) rv = 8'(m_cr);
`endif
    return rv;
  endfunction

  always @(posedge clock) begin : model
    logic [N-1:0] chg, nf, ncr;
    logic [7:0]   rv;
    if (reset) begin
      for (int p = 0; p < N; p++) begin
        m_port[p] = 8'h00;
        m_ddr[p]  = 8'h00;
`ifdef PMEM_GPIO_IRQ_EN
        m_msk[p]  = 8'h00;
`endif
      end
      m_flag = '0; m_cr = '0; m_irq = 1'b0; m_rdy = 1'b0; m_past = 1'b0; m_dout = 8'h00;
      h0 = '0; h1 = '0; h2 = '0;
      model_on = 1'b1;
    end else begin
      rv  = m_read(addr);
      chg = '0;
`ifdef PMEM_GPIO_IRQ_EN
      for (int p = 0; p < N; p++) chg[p] = |((h1[8*p +: 8] ^ h2[8*p +: 8]) & m_msk[p]);
`endif
      nf  = m_flag;
      ncr = m_cr;
      m_rdy = select;
      if (select) m_dout = write ? 8'h00 : rv;
      if (select && write) begin
        for (int p = 0; p < N; p++) begin
          if (addr == 8'(BASE + 4 * p) && !m_past) m_port[p] = m_port[p] ^ data_in;
          if (addr == 8'(BASE + 4 * p + 1))        m_ddr[p]  = data_in;
          if (addr == 8'(BASE + 4 * p + 2))        m_port[p] = data_in;
`ifdef PMEM_GPIO_IRQ_EN
          if (addr == 8'(BASE + 4 * p + 3))        m_msk[p]  = data_in;
`endif
        end
`ifdef PMEM_GPIO_IRQ_EN
        if (addr == 8'(BASE + 4 * N))     nf  = nf & ~data_in[N-1:0];
        if (addr == 8'(BASE + 4 * N + 1)) ncr = data_in[N-1:0];
`endif
      end
      nf     = nf | chg;
      m_irq  = |(nf & m_cr);
      m_flag = nf;
      m_cr   = ncr;
      m_past = select && write;
      h2 = h1; h1 = h0; h0 = io_in;
    end
  end

  always @(negedge clock) begin : compare
    logic [W-1:0] eo, eoeb;
    if (model_on) begin
      for (int p = 0; p < N; p++) begin
        eo[8*p +: 8]   = m_port[p];
        eoeb[8*p +: 8] = ~m_ddr[p];
      end
      chk("model data_ready", 16'(data_ready), 16'(m_rdy));
      chk("model data_out", 16'(data_out), 16'(m_dout));
      chk("model io_out", 16'(io_out), 16'(eo));
      chk("model io_oeb", 16'(io_oeb), 16'(eoeb));
      chk("model irq", 16'(irq), 16'(m_irq));
    end
  end

  task automatic access(input logic [7:0] a, input logic [7:0] d, input logic w, input int n);
    @(posedge clock); #2;
    select = 1'b1; addr = a; data_in = d; write = w;
    repeat (n) @(posedge clock);
    #2;
    select = 1'b0; write = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    chk("reset data_ready", 16'(data_ready), 16'h0);
    chk("reset io_oeb", 16'(io_oeb), 16'hFFFF);
    chk("reset io_out", 16'(io_out), 16'h0000);
    chk("reset irq", 16'(irq), 16'h0);

    access(8'h3B, 8'h00, 1'b0, 1);
    chk("ddr1 read", 16'(data_out), 16'h00);
    chk("ddr1 ready", 16'(data_ready), 16'h1);

    access(8'h3B, 8'h0F, 1'b1, 1);
    access(8'h3C, 8'hA5, 1'b1, 1);
    chk("ddr1 oeb", 16'(io_oeb[15:8]), 16'hF0);
    chk("port1 out", 16'(io_out[15:8]), 16'hA5);
    access(8'h3C, 8'h00, 1'b0, 1);
    chk("port1 read", 16'(data_out), 16'hA5);

    access(8'h36, 8'hFF, 1'b1, 3);
    chk("pin burst toggle", 16'(io_out[7:0]), 16'hFF);

    @(posedge clock); #2 io_in = 16'h00F0;
    repeat (3) @(posedge clock);
    access(8'h36, 8'h00, 1'b0, 1);
    chk("pin0 read", 16'(data_out), 16'hF0);

    access(8'h10, 8'h00, 1'b0, 1);
    chk("unmapped read", 16'(data_out), 16'h00);
    chk("unmapped ready", 16'(data_ready), 16'h1);

`ifdef PMEM_GPIO_IRQ_EN
    access(8'h39, 8'h01, 1'b1, 1);
    access(8'h3F, 8'h01, 1'b1, 1);
    @(posedge clock); #2 io_in = 16'h00F1;
    repeat (3) @(posedge clock);
    #2 chk("irq after change", 16'(irq), 16'h1);
    access(8'h3E, 8'h00, 1'b0, 1);
    chk("pcifr set", 16'(data_out), 16'h01);
    access(8'h3E, 8'h01, 1'b1, 1);
    chk("irq cleared", 16'(irq), 16'h0);
    access(8'h3E, 8'h00, 1'b0, 1);
    chk("pcifr cleared", 16'(data_out), 16'h00);
    // Clear lands on the same edge the next masked change sets the flag.
    @(posedge clock); #2 io_in = 16'h00F0;
    @(posedge clock);
    @(posedge clock); #2;
    select = 1'b1; addr = 8'h3E; data_in = 8'h01; write = 1'b1;
    @(posedge clock); #2;
    select = 1'b0; write = 1'b0;
    chk("set wins irq", 16'(irq), 16'h1);
    access(8'h3E, 8'h00, 1'b0, 1);
    chk("set wins flag", 16'(data_out), 16'h01);
    access(8'h3E, 8'h01, 1'b1, 1);
    chk("second clear irq", 16'(irq), 16'h0);
    access(8'h3F, 8'hFF, 1'b1, 1);
    access(8'h3F, 8'h00, 1'b0, 1);
    chk("pcicr high bits", 16'(data_out), 16'h03);
`else
    access(8'h39, 8'hFF, 1'b1, 1);
    access(8'h39, 8'h00, 1'b0, 1);
    chk("pcmsk unmapped", 16'(data_out), 16'h00);
    access(8'h3F, 8'hFF, 1'b1, 1);
    access(8'h3F, 8'h00, 1'b0, 1);
    chk("pcicr unmapped", 16'(data_out), 16'h00);
    @(posedge clock); #2 io_in = 16'h00F1;
    repeat (4) @(posedge clock);
    #2 chk("irq tied low", 16'(irq), 16'h0);
`endif

    access(8'h3C, 8'h00, 1'b0, 1);
    @(posedge clock); #2;
    select = 1'b1; addr = 8'h3C; data_in = 8'h5A; write = 1'b1; reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0; select = 1'b0; write = 1'b0;
    chk("rst io_out", 16'(io_out), 16'h0000);
    chk("rst io_oeb", 16'(io_oeb), 16'hFFFF);
    chk("rst data_ready", 16'(data_ready), 16'h0);
    chk("rst data_out", 16'(data_out), 16'h00);
    chk("rst irq", 16'(irq), 16'h0);

    access(8'h36, 8'h0F, 1'b1, 2);
    chk("post-reset pin toggle", 16'(io_out[7:0]), 16'h0F);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
